// File: rtl/feature_pkg.sv
// Shared widths, limits and FSM state type for the feature-extraction stages.
package feature_pkg;

  localparam int unsigned FEATURE_W = 16;
  localparam int unsigned BIN_W     = 16;

  localparam logic signed [FEATURE_W-1:0] FEATURE_MAX = 16'sd32767;

  typedef enum logic [1:0] {
    ACCUM,
    PAD,
    SKIP
  } state_e;

endpackage

// File: rtl/feature_binner_if.sv
// Bin input stream and feature output stream of feature_binner; no backpressure on either side.
interface feature_binner_if;
  import feature_pkg::*;

  logic [BIN_W-1:0]     bin_data_in;
  logic                 bin_valid_in;
  logic                 bin_last_in;
  logic [FEATURE_W-1:0] feature_data_out;
  logic                 feature_valid_out;
  logic                 feature_last_out;
  logic                 predict_enable_out;
  logic                 overflow_out;
  logic                 drop_out;

  modport master (
    output bin_data_in, bin_valid_in, bin_last_in,
    input  feature_data_out, feature_valid_out, feature_last_out, predict_enable_out,
    input  overflow_out, drop_out
  );

  modport slave (
    input  bin_data_in, bin_valid_in, bin_last_in,
    output feature_data_out, feature_valid_out, feature_last_out, predict_enable_out,
    output overflow_out, drop_out
  );

endinterface

// File: rtl/band_scaler.sv
// Combinational right shift of a band sum followed by saturation to a non-negative 16-bit word.
module band_scaler
  import feature_pkg::*;
#(
  parameter int unsigned AccW  = 19,
  parameter int unsigned Shift = 3
) (
  input  logic [AccW-1:0]      sum_i,
  output logic [FEATURE_W-1:0] feature_o
);

  localparam logic [AccW-1:0] MaxVal = AccW'(FEATURE_MAX);

  logic [AccW-1:0] shifted;

  always_comb begin
    shifted = sum_i >> Shift;
    if (shifted > MaxVal) begin
      feature_o = FEATURE_MAX;
    end else begin
      feature_o = shifted[FEATURE_W-1:0];
    end
  end

endmodule

// File: rtl/feature_binner.sv
// Groups per-frame FFT bins into fixed bands and emits one scaled feature word per band,
// padding short frames and ignoring surplus bins so every frame yields a full vector.
module feature_binner
  import feature_pkg::*;
#(
  parameter int unsigned NUM_FEATURES     = 4,
  parameter int unsigned BINS_PER_FEATURE = 8,
  parameter int unsigned SHIFT            = 3
) (
  input logic             clk_in,
  input logic             rst_in,
  feature_binner_if.slave bus
);

  localparam int unsigned AccW     = BIN_W + $clog2(BINS_PER_FEATURE + 1);
  localparam int unsigned BinCntW  = (BINS_PER_FEATURE > 1) ? $clog2(BINS_PER_FEATURE) : 1;
  localparam int unsigned BandCntW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [BinCntW-1:0]  LastBin  = BinCntW'(BINS_PER_FEATURE - 1);
  localparam logic [BandCntW-1:0] LastBand = BandCntW'(NUM_FEATURES - 1);

  state_e               state_q, state_d;
  logic [AccW-1:0]      acc_q, acc_d, sum_next;
  logic [BinCntW-1:0]   bin_cnt_q, bin_cnt_d;
  logic [BandCntW-1:0]  band_cnt_q, band_cnt_d;
  logic                 ovf_seen_q, ovf_seen_d;
  logic [FEATURE_W-1:0] data_q, data_d, scaled;
  logic                 valid_q, valid_d, last_q, last_d, ovf_q, ovf_d, drop_q, drop_d;
  logic                 band_done, final_band;

  assign sum_next   = acc_q + AccW'(bus.bin_data_in);
  assign band_done  = (bin_cnt_q == LastBin);
  assign final_band = (band_cnt_q == LastBand);

  band_scaler #(
    .AccW (AccW),
    .Shift(SHIFT)
  ) u_band_scaler (
    .sum_i    (sum_next),
    .feature_o(scaled)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      bin_cnt_q  <= '0;
      band_cnt_q <= '0;
      ovf_seen_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bin_cnt_q  <= bin_cnt_d;
      band_cnt_q <= band_cnt_d;
      ovf_seen_q <= ovf_seen_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bin_cnt_d  = bin_cnt_q;
    band_cnt_d = band_cnt_q;
    ovf_seen_d = ovf_seen_q;
    unique case (state_q)
      ACCUM: begin
        if (bus.bin_valid_in) begin
          if (bus.bin_last_in || band_done) begin
            acc_d     = '0;
            bin_cnt_d = '0;
            if (final_band) begin
              band_cnt_d = '0;
              ovf_seen_d = 1'b0;
              // A completed final band without last means surplus bins follow.
              if (!bus.bin_last_in) state_d = SKIP;
            end else begin
              band_cnt_d = band_cnt_q + 1'b1;
              if (bus.bin_last_in) state_d = PAD;
            end
          end else begin
            acc_d     = sum_next;
            bin_cnt_d = bin_cnt_q + 1'b1;
          end
        end
      end
      PAD: begin
        if (final_band) begin
          band_cnt_d = '0;
          state_d    = ACCUM;
        end else begin
          band_cnt_d = band_cnt_q + 1'b1;
        end
      end
      SKIP: begin
        if (bus.bin_valid_in) begin
          ovf_seen_d = 1'b1;
          if (bus.bin_last_in) state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    ovf_d   = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (bus.bin_valid_in && (bus.bin_last_in || band_done)) begin
          valid_d = 1'b1;
          data_d  = scaled;
          last_d  = final_band;
        end
      end
      PAD: begin
        valid_d = 1'b1;
        data_d  = '0;
        last_d  = final_band;
        drop_d  = bus.bin_valid_in;
      end
      SKIP:    ovf_d = bus.bin_valid_in && !ovf_seen_q;
      default: ;
    endcase
  end

  assign bus.feature_data_out   = data_q;
  assign bus.feature_valid_out  = valid_q;
  assign bus.feature_last_out   = last_q;
  assign bus.predict_enable_out = valid_q;
  assign bus.overflow_out       = ovf_q;
  assign bus.drop_out           = drop_q;

endmodule

// File: doc/feature_binner.md
Name: feature_binner

Overview:
- Upstream stage that feeds the classifier's feature stream.
- Consumes per-frame FFT magnitude bins (unsigned 16-bit, valid/last) and groups them into NUM_FEATURES bands of BINS_PER_FEATURE consecutive bins.
- Each band is summed, scaled by a right shift, saturated and emitted as one signed 16-bit feature word with valid/last/predict-enable.
- Every input frame produces exactly NUM_FEATURES output words, so the classifier always sees a complete vector.

Parameters:
NUM_FEATURES, 4, feature words per frame (matches classifier NUM_FEATURES_IN)
BINS_PER_FEATURE, 8, input bins summed per feature; power of two not required, >=1
SHIFT, 3, right shift applied to each band sum before saturation

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
bin_data_in  input  16  unsigned FFT magnitude bin
bin_valid_in  input  1  bin_data_in valid this cycle
bin_last_in  input  1  final bin of the frame (qualified by bin_valid_in)
feature_data_out  output  16  signed feature word, always in 0..32767
feature_valid_out  output  1  feature word valid
feature_last_out  output  1  final feature of the vector
predict_enable_out  output  1  high exactly when feature_valid_out is high
overflow_out  output  1  one-cycle pulse: first bin beyond NUM_FEATURES*BINS_PER_FEATURE in a frame
drop_out  output  1  one-cycle pulse: valid bin arrived while padding and was discarded

Behaviour:
- Reset (rst_in low, async): all outputs 0; accumulator, bin counter and band counter cleared; state ACCUM. A mid-frame reset discards the partial frame; the first valid bin after release is bin 0 of a new frame.
- No backpressure: there is no ready on either side; the block accepts a bin every cycle in ACCUM.
- Accumulator width: 16+clog2(BINS_PER_FEATURE+1) bits, unsigned. Scaled result = sum >> SHIFT; if result > 32767 output 32767, else the result. Sign bit is always 0.
- State ACCUM, valid bin:
  - The bin is added to the band sum.
  - When the bin completes a band, that band's feature is registered out on the next cycle (latency 1); the accumulator restarts at 0 for the next band.
  - feature_last_out is set on the word for band NUM_FEATURES-1.
- Early last (bin_last_in before the final band completes):
  - Next cycle: the partial band sum is emitted (scaled/saturated as above).
  - Go to PAD: remaining bands are emitted as 0, one per consecutive cycle; the final pad word carries last. Then return to ACCUM with counters cleared.
  - If last lands exactly on a band boundary, the completed band is emitted normally and padding covers only the bands after it.
- Last on the bin completing the final band: normal emission with last; counters cleared; ACCUM continues.
- Final band complete without last: state SKIP.
  - Further bins are ignored; overflow_out pulses once, on the first ignored bin.
  - bin_last_in in SKIP returns to ACCUM with counters cleared. No extra output words.
- PAD: any valid bin is discarded and drop_out pulses that cycle. A discarded last is ignored; the frame after PAD starts fresh.
- Outputs are registered; feature_data_out holds its value between valid words, and last/valid/predict_enable are 0 when not emitting.

Decomposition:
- Shared package feature_pkg: FEATURE_W=16, BIN_W=16, FEATURE_MAX=16'sd32767, and a state enum {ACCUM, PAD, SKIP}.
- One natural sub-module, band_scaler: combinational shift + saturate from accumulator width to 16 bits, reusable by other feature stages.
- Counters and FSM stay in feature_binner.

Test Plan:
- Defaults. 32 bins of 100, last on bin 32 -> four words of 100, valid one cycle after bins 8/16/24/32, last on fourth, predict_enable_out matches valid.
- 32 bins of 16'hFFFF -> each sum 524280>>3=65535 -> saturated 32767 ×4; last on fourth.
- 12 bins of 8, last on bin 12 -> words 8 (after bin 8), then 4, 0, 0 on consecutive cycles starting one cycle after bin 12, last on final 0.
- Two valid bins during the pad cycles of the previous case -> drop_out pulses twice, no extra accumulation; the next full frame of 100s yields four 100s.
- 40 bins of 1, last on bin 40 -> four words of 1 (8>>3), overflow_out single pulse at bin 33, no words after the fourth, next frame normal.
- Reset asserted after 5 bins of 50 -> outputs 0 immediately (async); after release, 32 bins of 200 -> four words of 200.
